// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: clear request, read ports, write port and status.
interface regfile_mp_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_READ   = 2
);
    logic                           CLR;
    logic [NUM_READ*ADDR_WIDTH-1:0] RA;
    logic [NUM_READ*DATA_WIDTH-1:0] RD;
    logic [ADDR_WIDTH-1:0]          A3;
    logic [DATA_WIDTH-1:0]          WD3;
    logic                           WE3;
    logic                           READY;
    logic                           WDROP;

    modport master (output CLR, RA, A3, WD3, WE3, input RD, READY, WDROP);
    modport slave  (input CLR, RA, A3, WD3, WE3, output RD, READY, WDROP);
endinterface

// File: rtl/regfile_mp.sv
// Multi-read, single-write register file with a sweeping hardware clear.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle writes onto matching read ports.
module regfile_mp_rdport #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0]                     ra,
    input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0]  mem,
    input  logic                                      ready,
    input  logic                                      byp,
    input  logic [DATA_WIDTH-1:0]                     wd,
    output logic [DATA_WIDTH-1:0]                     rd
);
    // Address 0 is hardwired to zero regardless of what the storage holds.
    always_comb begin
        rd = '0;
        if (ready && ra != '0) rd = byp ? wd : mem[ra];
    end
endmodule

module regfile_mp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_READ   = 2
) (
    input logic         CLK,
    input logic         RST_N,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]                          state, state_nxt;
    logic [ADDR_WIDTH-1:0]               cnt;
    logic                                ready_q, wdrop_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]    mem;
    logic                                wr_run;
    logic [NUM_READ-1:0][ADDR_WIDTH-1:0] ra;
    logic [NUM_READ-1:0][DATA_WIDTH-1:0] rd;
    logic [NUM_READ-1:0]                 byp;

    assign wr_run = (state == ST_RUN) && bus.WE3 && (bus.A3 != '0);

    // CLR during the sweep is ignored; only the last index ends it.
    always_comb begin
        state_nxt = state;
        if (state == ST_CLEAR) begin
            if (cnt == '1) state_nxt = ST_RUN;
        end else if (bus.CLR) begin
            state_nxt = ST_CLEAR;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_CLEAR;
            cnt     <= '0;
            ready_q <= 1'b0;
            wdrop_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt == ST_RUN);
            cnt     <= (state == ST_CLEAR) ? cnt + 1'b1 : '0;
            wdrop_q <= (state == ST_CLEAR) && bus.WE3 && (bus.A3 != '0);
        end
    end

    // Storage has no reset; it is zeroed only by the sweep.
    always_ff @(posedge CLK) begin
        if (state == ST_CLEAR) mem[cnt] <= '0;
        else if (wr_run)       mem[bus.A3] <= bus.WD3;
    end

    assign ra = bus.RA;

    genvar i;
    for (i = 0; i < NUM_READ; i++) begin : g_rd
`ifdef REGFILE_MP_BYPASS_EN
        assign byp[i] = wr_run && (bus.A3 == ra[i]);
`else
        assign byp[i] = 1'b0;
`endif
        regfile_mp_rdport #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_rd (
            .ra    (ra[i]),
            .mem   (mem),
            .ready (ready_q),
            .byp   (byp[i]),
            .wd    (bus.WD3),
            .rd    (rd[i])
        );
    end

    assign bus.RD    = rd;
    assign bus.READY = ready_q;
    assign bus.WDROP = wdrop_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: clear sweep timing, writes, reads, drops and reset aborts.
module tb_regfile_mp;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 2;
`ifdef REGFILE_MP_BYPASS_EN
    localparam logic [31:0] BYP_EXP = 32'hA5A5A5A5;
`else
    localparam logic [31:0] BYP_EXP = 32'h0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] rd0, rd1;

    always #5 clk = ~clk;

    regfile_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR)) bus ();

    regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    assign rd0 = bus.RD[31:0];
    assign rd1 = bus.RD[63:32];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        bus.WE3 = 1'b1;
        bus.A3  = AW'(a);
        bus.WD3 = d;
        tick();
        bus.WE3 = 1'b0;
    endtask

    // READY must stay low for n_low more cycles, then be high.
    task automatic sweep_chk(input string tag, input int n_low);
        for (int k = 0; k < n_low; k++) begin
            chk({tag, "_low"}, 32'(bus.READY), 32'd0);
            tick();
        end
        chk({tag, "_high"}, 32'(bus.READY), 32'd1);
    endtask

    task automatic all_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            bus.RA = {AW'(a), AW'(a)};
            #1;
            chk({tag, "_rd0"}, rd0, 32'd0);
            chk({tag, "_rd1"}, rd1, 32'd0);
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.CLR = 1'b0; bus.RA = '0; bus.A3 = '0; bus.WD3 = '0; bus.WE3 = 1'b0;
        repeat (3) tick();
        chk("rst_ready", 32'(bus.READY), 32'd0);
        chk("rst_wdrop", 32'(bus.WDROP), 32'd0);
        bus.RA = {AW'(7), AW'(7)};
        #1 chk("rst_rd0", rd0, 32'd0);
        tick();
        rst_n = 1'b1;
        sweep_chk("init_sweep", 32);
        all_zero("init");

        // Basic write/read, both ports on the same entry, address 0 ignored
        wr(7, 32'hDEADBEEF);
        bus.RA = {AW'(7), AW'(7)};
        #1 chk("wr7_rd0", rd0, 32'hDEADBEEF);
        chk("wr7_rd1", rd1, 32'hDEADBEEF);
        tick();
        wr(0, 32'h12345678);
        chk("wr0_wdrop", 32'(bus.WDROP), 32'd0);
        bus.RA = {AW'(0), AW'(0)};
        #1 chk("wr0_rd0", rd0, 32'd0);
        chk("wr0_rd1", rd1, 32'd0);
        tick();

        // Same-cycle write/read of entry 5
        bus.RA  = {AW'(7), AW'(5)};
        bus.WE3 = 1'b1; bus.A3 = AW'(5); bus.WD3 = 32'hA5A5A5A5;
        #1 chk("byp_same_rd0", rd0, BYP_EXP);
        chk("byp_other_rd1", rd1, 32'hDEADBEEF);
        tick();
        bus.WE3 = 1'b0;
        #1 chk("byp_next_rd0", rd0, 32'hA5A5A5A5);
        tick();

        // Fill 1..31 with index, then CLR with a concurrent write
        for (int a = 1; a < 32; a++) wr(a, 32'(a));
        bus.RA = {AW'(31), AW'(1)};
        #1 chk("fill_rd0_1", rd0, 32'd1);
        chk("fill_rd1_31", rd1, 32'd31);
        tick();
        bus.RA = {AW'(20), AW'(5)};
        #1 chk("fill_rd0_5", rd0, 32'd5);
        chk("fill_rd1_20", rd1, 32'd20);
        tick();
        bus.CLR = 1'b1; bus.WE3 = 1'b1; bus.A3 = AW'(3); bus.WD3 = 32'hFF;
        #1 chk("clr_ready_before", 32'(bus.READY), 32'd1);
        tick();
        bus.CLR = 1'b0; bus.WE3 = 1'b0;
        chk("clr_wdrop", 32'(bus.WDROP), 32'd0);
        bus.RA = {AW'(3), AW'(3)};
        #1 chk("clr_rd0_zero", rd0, 32'd0);
        sweep_chk("clr_sweep", 32);
        all_zero("clr");

        // Write during the sweep is dropped; CLR during the sweep is ignored
        bus.CLR = 1'b1;
        tick();
        bus.CLR = 1'b0;
        repeat (12) tick();
        bus.WE3 = 1'b1; bus.A3 = AW'(9); bus.WD3 = 32'h99; bus.CLR = 1'b1;
        chk("drop_wdrop_before", 32'(bus.WDROP), 32'd0);
        tick();
        bus.WE3 = 1'b0; bus.CLR = 1'b0;
        chk("drop_wdrop_pulse", 32'(bus.WDROP), 32'd1);
        tick();
        chk("drop_wdrop_after", 32'(bus.WDROP), 32'd0);
        sweep_chk("drop_sweep", 18);
        bus.RA = {AW'(9), AW'(9)};
        #1 chk("drop_rd0_9", rd0, 32'd0);
        chk("drop_rd1_9", rd1, 32'd0);
        tick();

        // Reset in RUN: outputs drop immediately, sweep restarts
        wr(31, 32'hCAFE0001);
        bus.RA = {AW'(31), AW'(31)};
        #1 chk("run_rd0_31", rd0, 32'hCAFE0001);
        #1 rst_n = 1'b0;
        #1 chk("rstrun_ready", 32'(bus.READY), 32'd0);
        chk("rstrun_rd0", rd0, 32'd0);
        chk("rstrun_rd1", rd1, 32'd0);
        tick();
        rst_n = 1'b1;
        sweep_chk("rstrun_sweep", 32);
        #1 chk("rstrun_rd0_31", rd0, 32'd0);
        tick();

        // Reset at counter 15 of a sweep: full sweep after release
        bus.CLR = 1'b1;
        tick();
        bus.CLR = 1'b0;
        repeat (15) tick();
        rst_n = 1'b0;
        #1 chk("rstclr_ready", 32'(bus.READY), 32'd0);
        chk("rstclr_rd0", rd0, 32'd0);
        chk("rstclr_wdrop", 32'(bus.WDROP), 32'd0);
        tick();
        rst_n = 1'b1;
        sweep_chk("rstclr_sweep", 32);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, address width; depth = 2**ADDR_WIDTH entries.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of each entry.
REQ-003 SHALL have parameter NUM_READ, default 2, number of independent read ports (1..8).
REQ-004 SHALL have ports: CLK  input  1  sole clock, rising edge.
REQ-005 SHALL have ports: RST_N  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: CLR  input  1  request to zero every entry.
REQ-007 SHALL have ports: RA  input  NUM_READ*ADDR_WIDTH  read addresses, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 SHALL have ports: RD  output  NUM_READ*DATA_WIDTH  read data, port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have ports: A3  input  ADDR_WIDTH  write address; WD3  input  DATA_WIDTH  write data; WE3  input  1  write enable.
REQ-010 SHALL have ports: READY  output  1  high when the array is usable; WDROP  output  1  one-cycle pulse when a write is discarded.

Function
REQ-011 SHALL use a two-state FSM: CLEAR and RUN.
REQ-012 In CLEAR, an ADDR_WIDTH-bit counter SHALL write zero to entry[counter] each cycle, incrementing from 0; when counter reaches 2**ADDR_WIDTH-1, the FSM SHALL enter RUN on the next edge; clearing takes exactly 2**ADDR_WIDTH cycles.
REQ-013 In RUN with CLR=1, the FSM SHALL enter CLEAR at the next edge with counter=0; CLR while in CLEAR SHALL be ignored (no restart).
REQ-014 READY SHALL be 1 only in RUN; it SHALL be registered and fall in the cycle after CLR is sampled.
REQ-015 In RUN, WE3=1 with A3!=0 SHALL write WD3 to entry[A3] at the rising edge; CLR=1 and WE3=1 in the same cycle SHALL perform the write, then start CLEAR.
REQ-016 WE3=1 while in CLEAR SHALL discard the write and assert WDROP for exactly the following cycle.
REQ-017 Writes to address 0 SHALL be ignored without WDROP; RD for address 0 SHALL always be zero.
REQ-018 Reads SHALL be combinational: RD port i = entry[RA port i] in RUN; all RD ports SHALL be zero whenever READY=0.
REQ-019 Any number of read ports addressing the same entry SHALL return identical data.
REQ-020 The array SHALL be 2**ADDR_WIDTH entries deep with no aliasing of any address.

Reset
REQ-021 RST_N low SHALL immediately force state=CLEAR, counter=0, READY=0, WDROP=0; RD SHALL therefore be zero.
REQ-022 The array storage itself SHALL NOT be asynchronously reset; zeroing occurs only via the CLEAR sweep after RST_N deasserts.
REQ-023 RST_N asserted mid-CLEAR or mid-RUN SHALL abort the current activity and restart the sweep from 0 on release.

Configuration
REQ-024 Macro REGFILE_MP_BYPASS_EN SHALL control write-to-read forwarding.
REQ-025 With REGFILE_MP_BYPASS_EN defined: in RUN, if WE3=1, A3!=0 and A3 equals RA port i, RD port i SHALL equal WD3 in that same cycle.
REQ-026 Without REGFILE_MP_BYPASS_EN: RD port i SHALL show the previous stored value until after the write edge.

Verification (ADDR_WIDTH=5, DATA_WIDTH=32, NUM_READ=2)
REQ-027 Release RST_N, hold WE3=0 -> READY=0 for 32 cycles, READY=1 on cycle 33; both RD ports = 0x00000000 for every address.
REQ-028 In RUN, write 0xDEADBEEF to 7, then read RA0=7, RA1=7 -> both ports 0xDEADBEEF; write 0x12345678 to 0 -> RD for address 0 = 0, WDROP=0.
REQ-029 Same-cycle WE3=1, A3=5, WD3=0xA5A5A5A5, RA0=5 -> RD0=0xA5A5A5A5 that cycle with REGFILE_MP_BYPASS_EN, old value without it; both builds show 0xA5A5A5A5 next cycle.
REQ-030 Fill entries 1..31 with their index, pulse CLR with WE3=1, A3=3, WD3=0xFF -> READY low for 32 cycles, then all entries read 0.
REQ-031 WE3=1, A3=9 during CLEAR -> WDROP=1 next cycle only; entry 9 reads 0 after READY.
REQ-032 Assert RST_N low at counter=15 of a CLEAR sweep -> READY=0 and RD=0 immediately; after release, full 32-cycle sweep before READY=1.
